// File: rtl/gl_commit_ctrl.sv
// Commit controller: retires up to two graduation-list heads per cycle.
// Serializes stores and CSR ops, turns a faulting head into trap + flush, and counts retirements.
module gl_commit_ctrl #(
  parameter int NUM_ENTRIES = 32,
  parameter int IDX_W       = $clog2(NUM_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             empty_i,
  input  logic [1:0]       head_valid_i,
  input  logic [1:0]       head_is_store_i,
  input  logic [1:0]       head_is_csr_i,
  input  logic [1:0]       head_ex_valid_i,
  input  logic [IDX_W-1:0] head_index_i,
  input  logic             halt_i,
  output logic             store_commit_valid_o,
  input  logic             store_commit_ready_i,
  output logic             csr_req_o,
  input  logic             csr_ack_i,
  input  logic             csr_ex_i,
  output logic [1:0]       read_head_o,
  output logic             flush_commit_o,
  output logic             trap_o,
  output logic [IDX_W-1:0] trap_index_o,
  output logic [63:0]      retired_cnt_o
);

  typedef enum logic [1:0] {RUN, STORE_WAIT, CSR_WAIT, TRAP} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] trap_idx_q;
  logic             trap_q;
  logic             latch_idx;
  logic [63:0]      cnt_q;
  logic             slot1_ok;

  assign slot1_ok = head_valid_i[1] & ~head_is_store_i[1] &
                    ~head_is_csr_i[1] & ~head_ex_valid_i[1];

  // Combinational outputs are held low while reset is asserted.
  always_comb begin
    state_d              = state_q;
    read_head_o          = 2'b00;
    store_commit_valid_o = 1'b0;
    csr_req_o            = 1'b0;
    latch_idx            = 1'b0;
    if (rstn_i) begin
      unique case (state_q)
        RUN: begin
          if (empty_i || halt_i || !head_valid_i[0]) begin
            state_d = RUN;
          end else if (head_ex_valid_i[0]) begin
            latch_idx = 1'b1;
            state_d   = TRAP;
          end else if (head_is_store_i[0]) begin
            store_commit_valid_o = 1'b1;
            if (store_commit_ready_i) read_head_o = 2'b01;
            else                      state_d     = STORE_WAIT;
          end else if (head_is_csr_i[0]) begin
            csr_req_o = 1'b1;
            state_d   = CSR_WAIT;
          end else begin
            read_head_o = slot1_ok ? 2'b11 : 2'b01;
          end
        end
        STORE_WAIT: begin
          store_commit_valid_o = 1'b1;
          if (store_commit_ready_i) begin
            read_head_o = 2'b01;
            state_d     = RUN;
          end
        end
        CSR_WAIT: begin
          if (csr_ack_i) begin
            if (csr_ex_i) begin
              latch_idx = 1'b1;
              state_d   = TRAP;
            end else begin
              read_head_o = 2'b01;
              state_d     = RUN;
            end
          end
        end
        TRAP: state_d = RUN;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= RUN;
      trap_q     <= 1'b0;
      trap_idx_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      trap_q  <= (state_d == TRAP);
      if (latch_idx) trap_idx_q <= head_index_i;
      cnt_q <= cnt_q + {63'd0, read_head_o[0]} + {63'd0, read_head_o[1]};
    end
  end

  assign trap_o         = trap_q;
  assign flush_commit_o = trap_q;
  assign trap_index_o   = trap_idx_q;
  assign retired_cnt_o  = cnt_q;

endmodule

// File: tb/tb_gl_commit_ctrl.sv
// Directed bench for gl_commit_ctrl: dual retire, store backpressure, CSR fault,
// slot-1 fault with index wrap, halt, counter wrap and reset during STORE_WAIT.
module tb_gl_commit_ctrl;
  localparam int NE = 32;
  localparam int IW = $clog2(NE);

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          empty_i;
  logic [1:0]    head_valid_i, head_is_store_i, head_is_csr_i, head_ex_valid_i;
  logic [IW-1:0] head_index_i;
  logic          halt_i;
  logic          store_commit_valid_o, store_commit_ready_i;
  logic          csr_req_o, csr_ack_i, csr_ex_i;
  logic [1:0]    read_head_o;
  logic          flush_commit_o, trap_o;
  logic [IW-1:0] trap_index_o;
  logic [63:0]   retired_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  gl_commit_ctrl #(.NUM_ENTRIES(NE)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .empty_i(empty_i),
    .head_valid_i(head_valid_i), .head_is_store_i(head_is_store_i),
    .head_is_csr_i(head_is_csr_i), .head_ex_valid_i(head_ex_valid_i),
    .head_index_i(head_index_i), .halt_i(halt_i),
    .store_commit_valid_o(store_commit_valid_o),
    .store_commit_ready_i(store_commit_ready_i),
    .csr_req_o(csr_req_o), .csr_ack_i(csr_ack_i), .csr_ex_i(csr_ex_i),
    .read_head_o(read_head_o), .flush_commit_o(flush_commit_o),
    .trap_o(trap_o), .trap_index_o(trap_index_o), .retired_cnt_o(retired_cnt_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    empty_i = 1'b1; head_valid_i = 2'b00; head_is_store_i = 2'b00;
    head_is_csr_i = 2'b00; head_ex_valid_i = 2'b00; head_index_i = '0;
    halt_i = 1'b0; store_commit_ready_i = 1'b0; csr_ack_i = 1'b0; csr_ex_i = 1'b0;
  endtask

  task automatic ordinary(input logic [1:0] vld, input logic [IW-1:0] idx);
    idle();
    empty_i = 1'b0; head_valid_i = vld; head_index_i = idx;
  endtask

  initial begin
    idle();
    rstn_i = 1'b0;
    #12;
    chk("rst_read_head", 64'(read_head_o), 64'd0);
    chk("rst_store_vld", 64'(store_commit_valid_o), 64'd0);
    chk("rst_csr_req", 64'(csr_req_o), 64'd0);
    chk("rst_trap", 64'({trap_o, flush_commit_o}), 64'd0);
    chk("rst_trap_idx", 64'(trap_index_o), 64'd0);
    chk("rst_cnt", retired_cnt_o, 64'd0);
    step();
    rstn_i = 1'b1;
    step();

    // five ordinary instructions: 11, 11, 01
    ordinary(2'b11, 5'd3); #1;
    chk("dual_rh0", 64'(read_head_o), 64'h3); step();
    head_index_i = 5'd5; #1;
    chk("dual_rh1", 64'(read_head_o), 64'h3); step();
    head_valid_i = 2'b01; head_index_i = 5'd7; #1;
    chk("dual_rh2", 64'(read_head_o), 64'h1); step();
    idle(); #1;
    chk("dual_cnt", retired_cnt_o, 64'd5);

    // store with three cycles of backpressure, ordinary slot 1 behind it
    ordinary(2'b11, 5'd8); head_is_store_i = 2'b01;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("st_vld_wait%0d", i), 64'(store_commit_valid_o), 64'd1);
      chk($sformatf("st_rh_wait%0d", i), 64'(read_head_o), 64'd0);
      step();
    end
    store_commit_ready_i = 1'b1; #1;
    chk("st_vld_rdy", 64'(store_commit_valid_o), 64'd1);
    chk("st_rh_rdy", 64'(read_head_o), 64'h1);
    step();
    idle(); #1;
    chk("st_cnt", retired_cnt_o, 64'd6);
    chk("st_vld_after", 64'(store_commit_valid_o), 64'd0);

    // CSR that faults on ack at cycle +4
    ordinary(2'b01, 5'd7); head_is_csr_i = 2'b01; #1;
    chk("csr_req_c0", 64'(csr_req_o), 64'd1);
    chk("csr_rh_c0", 64'(read_head_o), 64'd0);
    step();
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("csr_req_c%0d", i), 64'(csr_req_o), 64'd0);
      step();
    end
    csr_ack_i = 1'b1; csr_ex_i = 1'b1; #1;
    chk("csr_rh_ack", 64'(read_head_o), 64'd0);
    chk("csr_trap_early", 64'(trap_o), 64'd0);
    step();
    idle(); #1;
    chk("csr_trap", 64'({trap_o, flush_commit_o}), 64'h3);
    chk("csr_trap_idx", 64'(trap_index_o), 64'd7);
    chk("csr_trap_rh", 64'(read_head_o), 64'd0);
    step();
    chk("csr_trap_done", 64'(trap_o), 64'd0);
    chk("csr_cnt", retired_cnt_o, 64'd6);

    // slot 1 faults at index 31; it traps next cycle at wrapped index 0
    ordinary(2'b11, 5'd31); head_ex_valid_i = 2'b10; #1;
    chk("s1ex_rh0", 64'(read_head_o), 64'h1); step();
    ordinary(2'b01, 5'd0); head_ex_valid_i = 2'b01; #1;
    chk("s1ex_rh1", 64'(read_head_o), 64'd0); step();
    idle(); #1;
    chk("s1ex_trap", 64'(trap_o), 64'd1);
    chk("s1ex_idx", 64'(trap_index_o), 64'd0);
    step();
    chk("s1ex_cnt", retired_cnt_o, 64'd7);

    // halt blocks retirement
    ordinary(2'b11, 5'd1); halt_i = 1'b1; #1;
    chk("halt_rh", 64'(read_head_o), 64'd0); step();
    idle(); #1;
    chk("halt_cnt", retired_cnt_o, 64'd7);

    // counter wraps from all-ones
    force dut.cnt_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.cnt_q;
    ordinary(2'b11, 5'd31); #1;
    chk("wrap_rh", 64'(read_head_o), 64'h3); step();
    idle(); #1;
    chk("wrap_cnt", retired_cnt_o, 64'd1);

    // reset while in STORE_WAIT
    ordinary(2'b01, 5'd4); head_is_store_i = 2'b01; step();
    chk("rsw_vld_pre", 64'(store_commit_valid_o), 64'd1);
    rstn_i = 1'b0; #1;
    chk("rsw_vld", 64'(store_commit_valid_o), 64'd0);
    chk("rsw_rh", 64'(read_head_o), 64'd0);
    chk("rsw_cnt", retired_cnt_o, 64'd0);
    chk("rsw_trap", 64'({trap_o, flush_commit_o}), 64'd0);
    idle();
    step();
    rstn_i = 1'b1;
    step();
    chk("rsw_cnt_post", retired_cnt_o, 64'd0);
    ordinary(2'b01, 5'd2); head_is_csr_i = 2'b01; #1;
    chk("rsw_run_csr", 64'(csr_req_o), 64'd1);
    chk("rsw_run_st", 64'(store_commit_valid_o), 64'd0);
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/gl_commit_ctrl.md
Name: gl_commit_ctrl

Overview:
Commit-side controller that consumes the two oldest graduation-list entries each cycle. It decides how many retire (0, 1 or 2) and drives the read-head pulse back to the list. It also serializes stores to the store buffer and CSR operations to the CSR file, and converts a faulting head entry into a trap plus a full commit flush. A 64-bit retired-instruction counter feeds minstret.

Parameters:
NUM_ENTRIES, 32, graduation-list depth; must be a power of 2
IDX_W, $clog2(NUM_ENTRIES), width of a list index

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
empty_i  in  1  graduation list holds no entries
head_valid_i  in  2  [0] head entry finished and ready; [1] head+1 entry finished and ready
head_is_store_i  in  2  per slot: entry is a store or AMO
head_is_csr_i  in  2  per slot: entry is a CSR instruction
head_ex_valid_i  in  2  per slot: entry carries an exception
head_index_i  in  IDX_W  list index of slot 0
halt_i  in  1  debug halt; blocks new retirement
store_commit_valid_o  out  1  request to release the head store to the store buffer
store_commit_ready_i  in  1  store buffer accepts the request
csr_req_o  out  1  one-cycle pulse that starts the head CSR
csr_ack_i  in  1  CSR operation complete
csr_ex_i  in  1  CSR operation faulted; qualified by csr_ack_i
read_head_o  out  2  retire mask to the list: 00 none, 01 one, 11 two; 10 never driven
flush_commit_o  out  1  flush the whole list and pipeline
trap_o  out  1  take exception
trap_index_o  out  IDX_W  list index of the faulting entry
retired_cnt_o  out  64  total retired instructions

Behaviour:
- Reset (asynchronous, active-low): state=RUN; trap index register and counter cleared; every output 0.
- FSM states: RUN, STORE_WAIT, CSR_WAIT, TRAP. Outputs are combinational from the state and inputs, except trap_o, trap_index_o and flush_commit_o, which are registered.
- RUN, when empty_i=1, halt_i=1 or head_valid_i[0]=0:
  - read_head_o=00; stay in RUN.
- RUN, slot 0 has an exception:
  - read_head_o=00.
  - Latch head_index_i into the trap index register; go to TRAP.
- RUN, slot 0 is a store:
  - store_commit_valid_o=1 in the same cycle.
  - If store_commit_ready_i=1: read_head_o=01; stay in RUN.
  - Otherwise: go to STORE_WAIT.
  - A store always retires alone.
- RUN, slot 0 is a CSR:
  - csr_req_o=1 for this cycle only; read_head_o=00; go to CSR_WAIT.
- RUN, slot 0 is an ordinary instruction:
  - Retire it.
  - Also retire slot 1 (read_head_o=11) when head_valid_i[1]=1 and slot 1 is not a store, not a CSR and has no exception.
  - Otherwise read_head_o=01.
  - A faulting slot 1 is not retired; it becomes slot 0 in the next cycle and traps then.
- STORE_WAIT:
  - Hold store_commit_valid_o=1 until store_commit_ready_i=1.
  - In that cycle read_head_o=01; go to RUN.
  - halt_i is ignored.
- CSR_WAIT:
  - csr_req_o=0; wait for csr_ack_i.
  - On ack with csr_ex_i=0: read_head_o=01; go to RUN.
  - On ack with csr_ex_i=1: latch head_index_i; go to TRAP.
  - halt_i is ignored.
- TRAP, one cycle only:
  - trap_o=1, flush_commit_o=1, trap_index_o=latched index, read_head_o=00.
  - Next state is RUN.
  - The list resets its head, so inputs in the cycle after TRAP describe an empty list.
- Counter:
  - retired_cnt_o += number of set bits in read_head_o, registered (visible the next cycle).
  - Wraps modulo 2^64; no saturation.
- Invariants:
  - read_head_o is never 10.
  - store_commit_valid_o and csr_req_o are never asserted together.
  - At most one store and at most one CSR operation are retired per cycle.
- Index arithmetic is modulo NUM_ENTRIES: head_index_i = NUM_ENTRIES-1 with read_head_o=11 is legal, and the list handles the wrap.
- Reset asserted mid-operation (STORE_WAIT or CSR_WAIT) aborts immediately to the reset state; no store or CSR retirement is reported.

Test Plan:
- Dual retire: 5 ordinary instructions completed, halt_i=0 -> read_head_o sequence 11,11,01; retired_cnt_o reaches 5.
- Store backpressure: slot 0 store, store_commit_ready_i low for 3 cycles -> store_commit_valid_o high 4 cycles, a single 01 on the ready cycle, slot 1 not retired alongside.
- CSR fault: slot 0 CSR, csr_ack_i=1 and csr_ex_i=1 at cycle +4, head_index_i=7 -> one-cycle csr_req_o at cycle 0; trap_o=flush_commit_o=1 at cycle +5; trap_index_o=7; counter unchanged.
- Slot 1 exception: slot 0 ordinary, slot 1 faulting, head_index_i=31 -> cycle 0 read_head_o=01; cycle 1 sees head_index_i=0 and latches it; cycle 2 trap_o=1, trap_index_o=0.
- Counter wrap: preload retired_cnt_o to 2^64-1 (force), then retire 2 -> retired_cnt_o=1.
- Reset mid-STORE_WAIT: assert rstn_i=0 while waiting -> all outputs 0 asynchronously; after release, state is RUN and the counter is 0.
